multicycle_main_control: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and mux selects. Its `alu_op` output is the 2-bit code that the ALU control decoder consumes together with `funct`. Memory states hold until the memory acknowledges with `mem_ready`.

---
 rtl/multicycle_main_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_main_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath; jump support is built only with JUMP_EN defined.
// Outputs decode from the current state, and FETCH/MEM_READ/MEM_WRITE hold until mem_ready is seen.
module multicycle_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10
    } state_t;

    state_t r_state;

    logic w_is_r;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_is_j;
    logic w_illegal;

    assign w_is_r   = (opcode == OP_RTYPE);
    assign w_is_lw  = (opcode == OP_LW);
    assign w_is_sw  = (opcode == OP_SW);
    assign w_is_beq = (opcode == OP_BEQ);

`ifdef JUMP_EN
    assign w_is_j    = (opcode == OP_J);
    assign w_illegal = !(w_is_r || w_is_lw || w_is_sw || w_is_beq || w_is_j);
`else
    // Without jump support the J opcode is explicitly one of the illegal encodings.
    assign w_is_j    = 1'b0;
    assign w_illegal = !(w_is_r || w_is_lw || w_is_sw || w_is_beq) || (opcode == OP_J);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      r_state <= S_FETCH;
                S_FETCH:     r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (w_is_lw || w_is_sw) r_state <= S_MEM_ADDR;
                    else if (w_is_r)        r_state <= S_EXECUTE;
                    else if (w_is_beq)      r_state <= S_BRANCH;
                    else if (w_is_j)        r_state <= S_JUMP;
                    else                    r_state <= S_FETCH;
                end
                // IR is stable here, so the load/store split re-reads the opcode.
                S_MEM_ADDR:  r_state <= w_is_sw ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  r_state <= mem_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WB:    r_state <= S_FETCH;
                S_MEM_WRITE: r_state <= mem_ready ? S_FETCH : S_MEM_WRITE;
                S_EXECUTE:   r_state <= S_R_WB;
                S_R_WB:      r_state <= S_FETCH;
                S_BRANCH:    r_state <= S_FETCH;
`ifdef JUMP_EN
                S_JUMP:      r_state <= S_FETCH;
`endif
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    assign state = r_state;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = w_illegal;
                instr_done = w_illegal;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
`ifdef JUMP_EN
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
`endif
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed table, corner sequences and random instruction streams.
module tb_multicycle_main_control;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
`ifdef JUMP_EN
    localparam bit J_ON = 1'b1;
`else
    localparam bit J_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;
    logic [17:0] w_act;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    assign w_act = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    instr_done, illegal_op};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output vector the specification lists for each state code.
    function automatic logic [17:0] exp_out(input int s, input bit mr, input bit ill);
        logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, id, il;
        logic [1:0] ps, asb, aop;
        {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, id, il} = '0;
        ps = 2'b00; asb = 2'b00; aop = 2'b00;
        case (s)
            1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            2:  begin asb = 2'b11; id = ill; il = ill; end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mrd = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; id = 1; end
            6:  begin mwr = 1; io = 1; id = mr; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; id = 1; end
            9:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; id = 1; end
            10: begin pw = 1; ps = 2'b10; id = 1; end
            default: ;
        endcase
        return {pw, pwc, ps, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, id, il};
    endfunction

    // Reference: an instruction is a list of (state, mem_ready) steps derived from its class
    // and the number of wait cycles in the fetch and data-memory phases.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input bit rnd_op,
                             output int len, output int dones);
        int  st_q[$];
        bit  mr_q[$];
        bit  is_j, ill;
        is_j = J_ON && (op == OP_J);
        ill  = !(op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || is_j);
        for (int k = 0; k < fs; k++) begin st_q.push_back(1); mr_q.push_back(1'b0); end
        st_q.push_back(1); mr_q.push_back(1'b1);
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        if (op == OP_LW || op == OP_SW) begin
            st_q.push_back(3); mr_q.push_back(1'($urandom));
            for (int k = 0; k < ms; k++) begin
                st_q.push_back(op == OP_LW ? 4 : 6); mr_q.push_back(1'b0);
            end
            st_q.push_back(op == OP_LW ? 4 : 6); mr_q.push_back(1'b1);
            if (op == OP_LW) begin st_q.push_back(5); mr_q.push_back(1'($urandom)); end
        end else if (op == OP_R) begin
            st_q.push_back(7); mr_q.push_back(1'($urandom));
            st_q.push_back(8); mr_q.push_back(1'($urandom));
        end else if (op == OP_BEQ) begin
            st_q.push_back(9); mr_q.push_back(1'($urandom));
        end else if (is_j) begin
            st_q.push_back(10); mr_q.push_back(1'($urandom));
        end
        len = 0;
        dones = 0;
        for (int i = 0; i < st_q.size(); i++) begin
            mem_ready = mr_q[i];
            opcode = (st_q[i] == 2 || st_q[i] == 3 || !rnd_op) ? op : 6'($urandom);
            @(negedge clk);
            check("state", 32'(state), 32'(st_q[i]));
            check("outputs", 32'(w_act), 32'(exp_out(st_q[i], mr_q[i], ill && st_q[i] == 2)));
            if (instr_done) begin
                dones++;
                if (len == 0) len = i + 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench one step after a clock edge with the FSM in FETCH.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", 32'(state), 32'd0);
        check("idle_outputs", 32'(w_act), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0] op;
        int         fs;
        int         ms;
        int         exp_len;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   len, dones, d2;
        logic [5:0] op;

        vecs[0] = '{OP_R,    0, 0, 4};
        vecs[1] = '{OP_LW,   0, 2, 7};
        vecs[2] = '{OP_SW,   1, 0, 5};
        vecs[3] = '{OP_BEQ,  0, 0, 3};
        vecs[4] = '{OP_J,    0, 0, J_ON ? 3 : 2};
        vecs[5] = '{6'h3f,   2, 0, 4};
        vecs[6] = '{OP_LW,   1, 1, 7};

        rst_n = 1'b0;
        opcode = 6'h3f;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_state", 32'(state), 32'd0);
            check("reset_outputs", 32'(w_act), 32'd0);
        end
        release_reset();

        for (int i = 0; i < 7; i++) begin
            run_instr(vecs[i].op, vecs[i].fs, vecs[i].ms, 1'b0, len, dones);
            check($sformatf("vec%0d_len", i), 32'(len), 32'(vecs[i].exp_len));
            check($sformatf("vec%0d_dones", i), 32'(dones), 32'd1);
        end

        run_instr(OP_SW, 0, 0, 1'b0, len, dones);
        run_instr(OP_BEQ, 0, 0, 1'b0, len, d2);
        check("sw_beq_done_pulses", 32'(dones + d2), 32'd2);

        // Asynchronous reset while a load waits for memory.
        mem_ready = 1'b1;
        opcode = OP_LW;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("wait_state", 32'(state), 32'd4);
        check("wait_mem_read", 32'(mem_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 32'd0);
        check("async_reset_mem_read", 32'(mem_read), 32'd0);
        check("async_reset_outputs", 32'(w_act), 32'd0);
        release_reset();

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                default: op = 6'($urandom);
            endcase
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, len, dones);
            check("rand_dones", 32'(dones), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
